// File: rtl/mmm_pkg.sv
// Shared constants, state encoding and output decode for the
// Montgomery multiplier sequencer.
package mmm_pkg;

  localparam int N_BITS = 1026;
  localparam int CNT_W  = 11;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN,
    S_STORE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic rst_mmm;
    logic ld_a;
    logic ld_r;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{
    busy: 1'b0, done: 1'b0, rst_mmm: 1'b1,
    ld_a: 1'b0, ld_r: 1'b0
  };

  function automatic ctl_t ctl_of(state_t s);
    ctl_t c;
    c = CTL_IDLE;
    unique case (s)
      S_CLEAR: begin
        c.busy    = 1'b1;
        c.rst_mmm = 1'b0;
      end
      S_LOAD: begin
        c.busy = 1'b1;
        c.ld_a = 1'b1;
      end
      S_RUN:   c.busy = 1'b1;
      S_STORE: begin
        c.busy = 1'b1;
        c.ld_r = 1'b1;
      end
      S_DONE:  c.done = 1'b1;
      default: c = CTL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mmm_bit_cnt.sv
// A-bit index counter: clearable, enabled, holds at the
// final index so it can never run past the operand width.
module mmm_bit_cnt
  import mmm_pkg::*;
(
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  assign last = (cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mmm_ctrl.sv
// Sequencer for the bit-serial Montgomery multiplier datapath.
// Optional abort port pair when MMM_CTRL_ABORT_EN is defined.
module mmm_ctrl
  import mmm_pkg::*;
(
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rst_mmm,
  output logic             ld_a,
  output logic             ld_r,
  output logic             lock,
  output logic [CNT_W-1:0] bit_idx
`ifdef MMM_CTRL_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  state_t           state;
  state_t           state_nxt;
  ctl_t             ctl;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             abort_take;

`ifdef MMM_CTRL_ABORT_EN
  assign abort_take = abort &&
    (state == S_CLEAR || state == S_LOAD || state == S_RUN);
`else
  assign abort_take = 1'b0;
`endif

  mmm_bit_cnt u_cnt (
    .clk  (clk),
    .rstb (rstb),
    .en   (en && state == S_RUN),
    .clr  (en && (state == S_CLEAR || state == S_LOAD)),
    .cnt  (cnt),
    .last (cnt_last)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN:   if (cnt_last) state_nxt = S_STORE;
      S_STORE: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_take) state_nxt = S_IDLE;
  end

  // Everything advances only on enabled edges, so pulses stretch
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= S_IDLE;
      ctl   <= CTL_IDLE;
      lock  <= 1'b0;
`ifdef MMM_CTRL_ABORT_EN
      aborted <= 1'b0;
`endif
    end else if (en) begin
      state <= state_nxt;
      ctl   <= ctl_of(state_nxt);
      if (state == S_IDLE && state_nxt == S_CLEAR) begin
        lock <= 1'b0;
      end else if (state_nxt == S_STORE) begin
        lock <= 1'b1;
      end
`ifdef MMM_CTRL_ABORT_EN
      aborted <= abort_take;
`endif
    end
  end

  assign busy    = ctl.busy;
  assign done    = ctl.done;
  assign rst_mmm = ctl.rst_mmm;
  assign ld_a    = ctl.ld_a;
  assign ld_r    = ctl.ld_r;
  assign bit_idx = (state == S_RUN) ? cnt : '0;

endmodule

// File: tb/tb_mmm_ctrl.sv
// Self-checking bench for mmm_ctrl: position-based model plus
// directed scenarios with hand-computed cycle numbers.
module tb_mmm_ctrl;
  import mmm_pkg::*;

  localparam int P_RUN0  = 3;
  localparam int P_STORE = N_BITS + 3;
  localparam int P_DONE  = N_BITS + 4;
  localparam int LIM     = 3000;

  logic clk = 1'b0;
  logic rstb, en, start;
  logic busy, done, rst_mmm, ld_a, ld_r, lock;
  logic [CNT_W-1:0] bit_idx;
`ifdef MMM_CTRL_ABORT_EN
  logic abort, aborted;
  logic mab = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ndone = 0;
  logic done_d = 1'b0;
  int la_cyc, lr_cyc, nbusy;
  int n0;

  // Model: pos = enabled cycles since the accepting edge, 0 = idle
  int pos = 0;
  logic mlock = 1'b0;

  always #5 clk = ~clk;

  mmm_ctrl dut (
    .clk     (clk),
    .rstb    (rstb),
    .en      (en),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rst_mmm (rst_mmm),
    .ld_a    (ld_a),
    .ld_r    (ld_r),
    .lock    (lock),
    .bit_idx (bit_idx)
`ifdef MMM_CTRL_ABORT_EN
    ,
    .abort   (abort),
    .aborted (aborted)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp,
               $time);
    end
  endtask

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pos = 0;
      mlock = 1'b0;
`ifdef MMM_CTRL_ABORT_EN
      mab = 1'b0;
`endif
    end else if (en) begin
`ifdef MMM_CTRL_ABORT_EN
      mab = 1'b0;
      if (abort && pos >= 1 && pos < P_STORE) begin
        pos = 0;
        mab = 1'b1;
      end else
`endif
      if (pos == 0) begin
        if (start) begin
          pos = 1;
          mlock = 1'b0;
        end
      end else if (pos == P_DONE) begin
        pos = 0;
      end else begin
        pos++;
        if (pos == P_STORE) mlock = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(pos >= 1 && pos <= P_STORE));
    chk("done", 32'(done), 32'(pos == P_DONE));
    chk("rst_mmm", 32'(rst_mmm), 32'(pos != 1));
    chk("ld_a", 32'(ld_a), 32'(pos == 2));
    chk("ld_r", 32'(ld_r), 32'(pos == P_STORE));
    chk("lock", 32'(lock), 32'(mlock));
    chk("bit_idx", 32'(bit_idx),
        (pos >= P_RUN0 && pos < P_STORE) ? 32'(pos - P_RUN0) : 0);
`ifdef MMM_CTRL_ABORT_EN
    chk("aborted", 32'(aborted), 32'(mab));
`endif
    if (done && !done_d) ndone++;
    done_d = done;
  end

  task automatic adv();
    @(negedge clk);
    cyc++;
  endtask

  // start sampled at the next edge (edge 0); returns in cycle 1
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_idx(input int idx);
    int n;
    n = 0;
    while (!(busy && !ld_a && 32'(bit_idx) == idx) && n < LIM) begin
      adv();
      n++;
    end
    chk("wait_idx_timeout", 32'(bit_idx), 32'(idx));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    la_cyc = -1;
    lr_cyc = -1;
    nbusy = 0;
    while (!done && n < LIM) begin
      if (busy) nbusy++;
      if (ld_a && la_cyc < 0) la_cyc = cyc;
      if (ld_r && lr_cyc < 0) lr_cyc = cyc;
      adv();
      n++;
    end
    chk("wait_done_timeout", 32'(done), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b0;
    en = 1'b1;
    start = 1'b0;
`ifdef MMM_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rst_mmm", 32'(rst_mmm), 1);
    chk("rst_lock", 32'(lock), 0);
    chk("rst_bit_idx", 32'(bit_idx), 0);
    rstb = 1'b1;
    adv();

    // single operation, full latency
    pulse_start();
    chk("clear_rst_mmm", 32'(rst_mmm), 0);
    wait_done();
    chk("done_cycle", 32'(cyc), 1030);
    chk("ld_a_cycle", 32'(la_cyc), 2);
    chk("ld_r_cycle", 32'(lr_cyc), 1029);
    chk("busy_cycles", 32'(nbusy), 1029);
    adv();
    chk("lock_after", 32'(lock), 1);
    chk("idle_after", 32'(busy), 0);
    adv();

    // 5-cycle enable gap at bit 500
    pulse_start();
    wait_idx(500);
    chk("gap_at_cycle", 32'(cyc), 503);
    en = 1'b0;
    repeat (5) begin
      adv();
      chk("gap_hold_idx", 32'(bit_idx), 500);
    end
    en = 1'b1;
    adv();
    chk("gap_resume_idx", 32'(bit_idx), 501);
    wait_done();
    chk("gap_done_cycle", 32'(cyc), 1035);
    adv();

    // async reset at bit 700
    pulse_start();
    wait_idx(700);
    n0 = ndone;
    #2 rstb = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_idx", 32'(bit_idx), 0);
    chk("mid_rst_rst_mmm", 32'(rst_mmm), 1);
    chk("mid_rst_lock", 32'(lock), 0);
    adv();
    adv();
    rstb = 1'b1;
    adv();
    adv();
    chk("mid_rst_no_done", 32'(ndone - n0), 0);
    pulse_start();
    wait_done();
    chk("post_rst_done_cycle", 32'(cyc), 1030);
    chk("post_rst_ld_r", 32'(lr_cyc), 1029);
    adv();

    // start pulses in RUN and DONE are ignored
    n0 = ndone;
    pulse_start();
    wait_idx(100);
    start = 1'b1;
    adv();
    start = 1'b0;
    wait_done();
    chk("ign_done_cycle", 32'(cyc), 1030);
    start = 1'b1;
    adv();
    start = 1'b0;
    repeat (3) adv();
    chk("ign_idle", 32'(busy), 0);
    chk("ign_one_done", 32'(ndone - n0), 1);

    // start held high: back-to-back operations
    start = 1'b1;
    adv();
    cyc = 1;
    wait_done();
    chk("b2b_first", 32'(cyc), 1030);
    adv();
    wait_done();
    chk("b2b_second", 32'(cyc), 2061);
    start = 1'b0;
    repeat (3) adv();
    chk("b2b_idle", 32'(busy), 0);

`ifdef MMM_CTRL_ABORT_EN
    n0 = ndone;
    pulse_start();
    wait_idx(10);
    abort = 1'b1;
    adv();
    abort = 1'b0;
    chk("abort_idle", 32'(busy), 0);
    chk("abort_pulse", 32'(aborted), 1);
    chk("abort_lock", 32'(lock), 0);
    adv();
    chk("abort_pulse_end", 32'(aborted), 0);
    repeat (3) adv();
    chk("abort_no_done", 32'(ndone - n0), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmm_ctrl.md
MMM_CTRL -- requirements
Module: mmm_ctrl

Interface
REQ-001 Parameters: none; operand width comes from package constant N_BITS = 1026 (bits of A/B/M/R in the multiplier datapath).
REQ-002 Reset is asynchronous and active-low; one clock; ports named clk and rstb.
REQ-003 clk  input  1  single system clock, all state updates on rising edge.
REQ-004 rstb  input  1  asynchronous active-low reset.
REQ-005 en  input  1  global enable; when 0 the FSM and counter hold state; it is the same enable fed to the datapath.
REQ-006 start  input  1  request a new multiplication; sampled only in IDLE with en=1.
REQ-007 busy  output  1  high while an operation is in progress (CLEAR through STORE).
REQ-008 done  output  1  one-cycle pulse when result is latched.
REQ-009 rst_mmm  output  1  active-low synchronous clear to multiplier accumulator and shift registers.
REQ-010 ld_a  output  1  one-cycle load of operand A into the A shift register.
REQ-011 ld_r  output  1  one-cycle capture of accumulator into result register.
REQ-012 lock  output  1  holds result register stable; high from STORE until next accepted start.
REQ-013 bit_idx  output  11  index of A bit being processed in RUN (0..N_BITS-1), 0 otherwise.

Function
REQ-014 States: IDLE, CLEAR, LOAD, RUN, STORE, DONE; encoded as a package enum.
REQ-015 IDLE -> CLEAR on rising edge with en=1 and start=1; start in any other state or with en=0 is ignored (no queuing).
REQ-016 CLEAR: rst_mmm=0 for exactly one cycle; next LOAD.
REQ-017 LOAD: ld_a=1 for exactly one cycle, bit counter cleared to 0; next RUN.
REQ-018 RUN: counter increments each enabled cycle; RUN lasts exactly N_BITS enabled cycles; when counter = N_BITS-1, next STORE; counter never exceeds N_BITS-1.
REQ-019 STORE: ld_r=1 one cycle, lock rises this cycle; next DONE.
REQ-020 DONE: done=1 one cycle, busy=0; next IDLE unconditionally.
REQ-021 Latency with en held 1: start sampled at edge 0 -> CLEAR cycle 1, LOAD 2, RUN 3..1028, STORE 1029, done high in cycle 1030.
REQ-022 lock falls on the edge that accepts the next start (CLEAR cycle has lock=0).
REQ-023 en=0 in any state: state, counter, and all outputs held; single-cycle pulses (ld_a, ld_r, done, rst_mmm low) are stretched, not repeated or dropped; operation resumes with identical remaining cycle count.
REQ-024 All outputs registered or decoded from state register only; no combinational path from start to any output.

Reset
REQ-025 rstb=0 forces asynchronously: state IDLE, counter 0, busy=0, done=0, rst_mmm=1, ld_a=0, ld_r=0, lock=0, bit_idx=0.
REQ-026 Reset mid-operation abandons it; no done pulse; first start after release begins a full new sequence.

Configuration
REQ-027 Macro MMM_CTRL_ABORT_EN defined: adds input abort (1 bit) and output aborted (1 bit); abort=1 with en=1 in CLEAR, LOAD or RUN moves to IDLE next edge, aborted pulses one cycle, done not asserted, lock stays 0; abort in STORE/DONE/IDLE ignored.
REQ-028 Macro undefined: abort and aborted ports absent; behaviour per REQ-014..REQ-024 only.

Structure
REQ-029 Package mmm_pkg holds N_BITS, CNT_W = 11, and the state enum type.
REQ-030 One sub-module mmm_bit_cnt: enabled, clearable, saturating-at-terminal counter producing count and last flag; FSM in mmm_ctrl.

Verification
REQ-031 Reset then start pulse, en=1 -> ld_a in cycle 2, 1026 RUN cycles, ld_r cycle 1029, done cycle 1030, lock=1 after.
REQ-032 start held high continuously -> back-to-back operations, each 1031 cycles start-to-IDLE, lock drops in each CLEAR.
REQ-033 en=0 for 5 cycles during RUN at bit_idx=500 -> done delayed exactly 5 cycles, bit_idx resumes at 500.
REQ-034 rstb asserted at bit_idx=700 -> all outputs at reset values immediately, no done; new start gives full 1026-cycle RUN.
REQ-035 start pulsed during RUN and DONE -> ignored, single done observed.
REQ-036 With MMM_CTRL_ABORT_EN, abort at bit_idx=10 -> IDLE next cycle, aborted=1 one cycle, done=0, lock=0.
